instruction_memory2: RTL and testbench

Byte-addressed, little-endian instruction memory for the simple processor's fetch stage. It returns the 32-bit instruction at byte address `i_add` through a fixed multi-cycle byte-serial read. Each fetch is started by the counter reset `i_rstCounter_`. Contents are loaded by the bench by hierarchical write into the byte array of the internal RAM instance.

---
 rtl/imem_pkg.sv | 13 +
 rtl/byte_ram.sv | 15 +
 rtl/instruction_memory2.sv | 55 +++++
 tb/tb_instruction_memory2.sv | 135 +++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared constants and types for the byte-serial instruction memory.
// Imported by the RAM and the fetch/assembly top.
package imem_pkg;
    localparam int DEPTH_DEF   = 256;
    localparam int WORD_W      = 32;
    localparam int BYTE_W      = 8;
    localparam int FETCH_BYTES = 4;
    localparam int CNT_W       = 3;

    typedef logic [BYTE_W-1:0] byte_t;
    typedef logic [WORD_W-1:0] word_t;
    typedef logic [CNT_W-1:0]  cnt_t;
endpackage

// File: rtl/byte_ram.sv
// Byte-wide storage with a single asynchronous read port.
// Contents are loaded from outside through memoryCell.
module byte_ram
    import imem_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic [AW-1:0]     addr,
    output logic [BYTE_W-1:0] rdata
);
    byte_t memoryCell [0:DEPTH-1];

    assign rdata = memoryCell[addr];
endmodule

// File: rtl/instruction_memory2.sv
// Fetch-stage instruction memory: assembles a little-endian word
// from four serial byte reads after each counter reset.
module instruction_memory2
    import imem_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_rstCounter_,
    input  logic [WORD_W-1:0] i_add,
    input  logic              i_en,
    output logic [WORD_W-1:0] o_ins
);
    logic [AW-1:0] a_q;
    cnt_t          cnt;
    logic [23:0]   shadow;
    byte_t         rd;
    logic [AW-1:0] rd_addr;
    logic          busy;

    // Only the low AW address bits select a cell.
    logic unused_add;
    assign unused_add = &{1'b0, i_add[WORD_W-1:AW]};

    // Offset addition wraps naturally modulo DEPTH.
    assign rd_addr = a_q + AW'(cnt);
    assign busy    = (cnt != cnt_t'(FETCH_BYTES));

    byte_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) r0 (
        .addr  (rd_addr),
        .rdata (rd)
    );

    always_ff @(posedge i_clk) begin
        if (i_rstCounter_) begin
            cnt    <= '0;
            o_ins  <= '0;
            shadow <= '0;
            a_q    <= i_add[AW-1:0];
        end else if (i_en && busy) begin
            unique case (cnt)
                3'd0:    shadow[7:0]   <= rd;
                3'd1:    shadow[15:8]  <= rd;
                3'd2:    shadow[23:16] <= rd;
                3'd3:    o_ins         <= {rd, shadow};
                default: ;
            endcase
            cnt <= cnt + 3'd1;
        end
    end
endmodule

// File: tb/tb_instruction_memory2.sv
// Directed plus randomized checks of the byte-serial instruction fetch
// against a word-level reference model.
module tb_instruction_memory2;
    localparam int DEPTH = 256;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] add = '0;
    logic        en  = 1'b0;
    logic [31:0] ins;

    int          n_cmp = 0;
    int          n_bad = 0;

    logic [7:0]  mem [0:DEPTH-1];
    int          m_n   = 0;
    int          m_a   = 0;
    logic [31:0] m_exp = '0;

    instruction_memory2 dut (
        .i_clk         (clk),
        .i_rstCounter_ (rst),
        .i_add         (add),
        .i_en          (en),
        .o_ins         (ins)
    );

    always #5 clk = ~clk;

    task automatic poke(input int a, input logic [7:0] v);
        mem[a] = v;
        dut.r0.memoryCell[a] = v;
    endtask

    function automatic logic [31:0] word_at(input int a);
        return {mem[(a + 3) % DEPTH], mem[(a + 2) % DEPTH],
                mem[(a + 1) % DEPTH], mem[a % DEPTH]};
    endfunction

    task automatic check(input string tag, input logic [31:0] exp);
        n_cmp++;
        assert (ins === exp) else begin
            n_bad++;
            $error("FAIL %s: got %h want %h", tag, ins, exp);
        end
    endtask

    // One clock with given inputs; model counts enabled edges since reset.
    task automatic step(input logic r, input logic e, input logic [31:0] a);
        rst = r;
        en  = e;
        add = a;
        @(posedge clk);
        #1;
        if (r) begin
            m_n   = 0;
            m_exp = '0;
            m_a   = int'(a % DEPTH);
        end else if (e && m_n < 4) begin
            m_n++;
            if (m_n == 4) m_exp = word_at(m_a);
        end
        check("model", m_exp);
    endtask

    task automatic fetch(input logic [31:0] a, input logic [31:0] exp);
        step(1'b1, 1'b1, a);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1, a);
        check("fetch", exp);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) poke(i, 8'($urandom));
        poke(0, 8'h00);  poke(1, 8'h08);  poke(2, 8'h43);  poke(3, 8'h04);
        poke(4, 8'h04);  poke(5, 8'h00);  poke(6, 8'h61);  poke(7, 8'h08);
        poke(8, 8'h04);  poke(9, 8'h00);  poke(10, 8'h62); poke(11, 8'h10);
        poke(12, 8'h00); poke(13, 8'h00); poke(14, 8'h61); poke(15, 8'h08);

        step(1'b1, 1'b0, 32'd0);
        check("reset", 32'h0);

        fetch(32'd0, 32'h04430800);
        fetch(32'd4, 32'h08610004);
        fetch(32'd8, 32'h10620004);
        fetch(32'd12, 32'h08610000);

        // Address change without reset is ignored.
        step(1'b1, 1'b1, 32'd0);
        step(1'b0, 1'b1, 32'd0);
        step(1'b0, 1'b1, 32'd0);
        step(1'b0, 1'b1, 32'd8);
        step(1'b0, 1'b1, 32'd8);
        check("addr_ignored", 32'h04430800);
        step(1'b1, 1'b1, 32'd8);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 32'd8);
        check("addr_rearm", 32'h10620004);

        // Enable stall: three idle cycles delay completion by three.
        step(1'b1, 1'b1, 32'd4);
        step(1'b0, 1'b1, 32'd4);
        step(1'b0, 1'b1, 32'd4);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'd4);
        step(1'b0, 1'b1, 32'd4);
        check("stall_not_done", 32'h0);
        step(1'b0, 1'b1, 32'd4);
        check("stall_done", 32'h08610004);

        // Reset mid-fetch aborts and rearms.
        step(1'b1, 1'b1, 32'd0);
        step(1'b0, 1'b1, 32'd0);
        step(1'b0, 1'b1, 32'd0);
        step(1'b1, 1'b1, 32'd12);
        check("abort_zero", 32'h0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 32'd12);
        check("abort_wait", 32'h0);
        step(1'b0, 1'b1, 32'd12);
        check("abort_done", 32'h08610000);

        // Randomized sequences, backdoor writes only before reads start.
        for (int i = 0; i < 400; i++) begin
            if ((m_n == 0 || m_n == 4) && $urandom_range(0, 3) == 0)
                poke(int'($urandom_range(0, DEPTH - 1)), 8'($urandom));
            step($urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0,
                 $urandom);
        end

        // Wrap-around at the top of the array.
        poke(254, 8'hAA); poke(255, 8'hBB); poke(0, 8'hCC); poke(1, 8'hDD);
        fetch(32'(DEPTH - 2), 32'hDDCCBBAA);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
